// File: rtl/clock_period_meter.sv
// clock_period_meter
//
// Measures the period and high time of a slow, asynchronous clock-like input
// in MasterClock cycles. The input is brought into the MasterClock domain
// through a two-flop synchronizer. A third flop keeps the previous sample so
// that rising and falling edges can be detected.
//
// One measurement is published per input period. PeriodCycles, HighCycles and
// PeriodNs update together, and MeasureValid pulses for one cycle when they
// change. If no rising edge arrives within TimeoutCycles, the sticky Stalled
// flag is raised and the meter re-arms. It then waits for two fresh rising
// edges before it publishes again.

module clock_period_meter #(
    parameter int unsigned MasterPeriod  = 8,
    parameter int unsigned CountWidth    = 32,
    parameter int unsigned TimeoutCycles = 125_000_000
) (
    input  logic                  MasterClock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic                  MeasuredClock,
    output logic [CountWidth-1:0] PeriodCycles,
    output logic [CountWidth-1:0] HighCycles,
    output logic [CountWidth-1:0] PeriodNs,
    output logic                  MeasureValid,
    output logic                  Stalled
);

    // FSM encoding: armed-and-waiting versus actively timing a period.
    localparam logic [0:0] WAIT_FIRST = 1'b0;
    localparam logic [0:0] MEASURING  = 1'b1;

    localparam logic [CountWidth-1:0] TIMEOUT      = CountWidth'(TimeoutCycles);
    localparam logic [CountWidth-1:0] PERIOD_SCALE = CountWidth'(MasterPeriod);
    localparam logic [CountWidth-1:0] CNT_ONE      = CountWidth'(1);

    // Synchronizer chain: sync_meta may go metastable; sync_stable is the
    // first sample trusted by the logic; sync_hist is the previous value.
    logic sync_meta;
    logic sync_stable;
    logic sync_hist;

    // Edge and control decodes.
    logic rise;
    logic fall;
    logic measuring;
    logic publish;
    logic timeout_hit;

    // Measurement state.
    logic [0:0]            state;
    logic [CountWidth-1:0] cnt;
    logic [CountWidth-1:0] high_latch;

    // Bring the asynchronous input into the MasterClock domain and keep one
    // extra sample of history for edge detection. This chain keeps running
    // while Enable is low, so an edge already present at re-enable is seen.
    always_ff @(posedge MasterClock) begin
        // NOTE: state elements take non-blocking assignments so that every
        // flop samples the pre-edge value of its neighbour; with blocking
        // assignments the three stages would collapse into one.
        if (Reset) begin
            sync_meta   <= 1'b0;
            sync_stable <= 1'b0;
            sync_hist   <= 1'b0;
        end else begin
            sync_meta   <= MeasuredClock;
            sync_stable <= sync_meta;
            sync_hist   <= sync_stable;
        end
    end

    // Decode edges, and decide whether this cycle publishes or times out.
    // A rise that coincides with the counter reaching TIMEOUT wins, so a
    // period of exactly TimeoutCycles is still reported.
    always_comb begin
        rise        = sync_stable & ~sync_hist;
        fall        = ~sync_stable & sync_hist;
        measuring   = (state == MEASURING);
        publish     = Enable & measuring & rise;
        timeout_hit = Enable & measuring & ~rise & (cnt == TIMEOUT);
    end

    // Run the FSM and the period counter. cnt is 1 on the cycle after a
    // rise, so the next rise P cycles later sees cnt == P.
    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            state <= WAIT_FIRST;
            cnt   <= '0;
        end else if (!Enable) begin
            state <= WAIT_FIRST;
            cnt   <= '0;
        end else if (rise) begin
            state <= MEASURING;
            cnt   <= CNT_ONE;
        end else if (!measuring || timeout_hit) begin
            state <= WAIT_FIRST;
            cnt   <= '0;
        end else if (cnt != TIMEOUT) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Capture the high time on each falling edge. While the meter is waiting
    // for its first rise, cnt is 0, and so a fall there records 0.
    always_ff @(posedge MasterClock) begin
        if (Reset || !Enable) begin
            high_latch <= '0;
        end else if (fall) begin
            high_latch <= cnt;
        end
    end

    // Publish a measurement on each rise while measuring. Also maintain the
    // sticky stall flag. The published values hold across stalls and across
    // disabled periods.
    always_ff @(posedge MasterClock) begin
        if (Reset) begin
            PeriodCycles <= '0;
            HighCycles   <= '0;
            PeriodNs     <= '0;
            MeasureValid <= 1'b0;
            Stalled      <= 1'b0;
        end else begin
            MeasureValid <= publish;
            if (publish) begin
                PeriodCycles <= cnt;
                HighCycles   <= high_latch;
                PeriodNs     <= cnt * PERIOD_SCALE;
                Stalled      <= 1'b0;
            end else if (timeout_hit) begin
                Stalled <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter
//
// Drives MeasuredClock synchronously to MasterClock, one level per cycle.
// Every cycle the outputs are compared with a reference model. The model
// works from edge timestamps: a period is the distance between two detected
// rises, a high time is the distance from a rise to the following fall, and
// a stall is a gap longer than the timeout. The synchronizer is modelled as a
// pure sampling latency.

module tb_clock_period_meter;

    localparam int unsigned MASTER_PERIOD = 8;
    localparam int unsigned COUNT_WIDTH   = 32;
    localparam int unsigned TIMEOUT       = 100;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   enable;
    logic                   measured;
    logic [COUNT_WIDTH-1:0] period_cycles;
    logic [COUNT_WIDTH-1:0] high_cycles;
    logic [COUNT_WIDTH-1:0] period_ns;
    logic                   measure_valid;
    logic                   stalled;

    clock_period_meter #(
        .MasterPeriod (MASTER_PERIOD),
        .CountWidth   (COUNT_WIDTH),
        .TimeoutCycles(TIMEOUT)
    ) dut (
        .MasterClock  (clk),
        .Reset        (reset),
        .Enable       (enable),
        .MeasuredClock(measured),
        .PeriodCycles (period_cycles),
        .HighCycles   (high_cycles),
        .PeriodNs     (period_ns),
        .MeasureValid (measure_valid),
        .Stalled      (stalled)
    );

    always #4 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Levels that are applied to reset and enable on the next tick.
    logic rst_drv;
    logic en_drv;

    // Reference model state.
    bit          seen_1, seen_2, seen_3;   // synchronized input at p-1, p-2, p-3
    bit          rst_1, rst_2;             // reset sampled at p-1, p-2
    bit          armed;
    int          last_rise;
    logic [31:0] latch_high;
    logic [31:0] exp_period, exp_high, exp_ns;
    logic        exp_valid, exp_stalled;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    // Advance the model by one MasterClock edge, given the inputs at that edge.
    task automatic model_step(input logic in_now, input logic rst_now,
                              input logic en_now);
        bit rise_now, fall_now;
        rise_now = !rst_1 && !rst_2 &&  seen_2 && !seen_3;
        fall_now = !rst_1 && !rst_2 && !seen_2 &&  seen_3;
        seen_3 = seen_2;
        seen_2 = seen_1;
        seen_1 = rst_now ? 1'b0 : in_now;
        rst_2  = rst_1;
        rst_1  = rst_now;

        exp_valid = 1'b0;
        if (rst_now) begin
            armed       = 1'b0;
            latch_high  = '0;
            exp_period  = '0;
            exp_high    = '0;
            exp_ns      = '0;
            exp_stalled = 1'b0;
        end else if (!en_now) begin
            armed      = 1'b0;
            latch_high = '0;
        end else begin
            if (fall_now)
                latch_high = armed ? 32'(cyc - last_rise) : 32'd0;
            if (rise_now) begin
                if (armed) begin
                    exp_period  = 32'(cyc - last_rise);
                    exp_high    = latch_high;
                    exp_ns      = 32'(exp_period * MASTER_PERIOD);
                    exp_valid   = 1'b1;
                    exp_stalled = 1'b0;
                end
                armed     = 1'b1;
                last_rise = cyc;
            end else if (armed && (cyc - last_rise) == int'(TIMEOUT)) begin
                exp_stalled = 1'b1;
                armed       = 1'b0;
            end
        end
    endtask

    // One MasterClock cycle: drive on the falling edge, update the model at
    // the rising edge, and compare shortly after it.
    task automatic tick(input logic val);
        @(negedge clk);
        measured = val;
        reset    = rst_drv;
        enable   = en_drv;
        @(posedge clk);
        cyc++;
        model_step(val, rst_drv, en_drv);
        #1;
        check("valid",   32'(measure_valid), 32'(exp_valid));
        check("stalled", 32'(stalled),       32'(exp_stalled));
        check("period",  period_cycles,      exp_period);
        check("high",    high_cycles,        exp_high);
        check("ns",      period_ns,          exp_ns);
    endtask

    task automatic level(input logic val, input int n);
        for (int i = 0; i < n; i++) tick(val);
    endtask

    task automatic run(input int high, input int low, input int periods);
        for (int i = 0; i < periods; i++) begin
            level(1'b1, high);
            level(1'b0, low);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; measured = 1'b0;
        rst_drv = 1'b1; en_drv = 1'b1;
        seen_1 = 0; seen_2 = 0; seen_3 = 0; rst_1 = 1; rst_2 = 1;
        armed = 0; last_rise = 0; latch_high = '0;
        exp_period = '0; exp_high = '0; exp_ns = '0;
        exp_valid = 1'b0; exp_stalled = 1'b0;

        // Reset state.
        level(1'b0, 4);
        check("reset_period", period_cycles, 32'd0);
        check("reset_stalled", 32'(stalled), 32'd0);
        rst_drv = 1'b0;

        // Steady 8/8 input.
        run(8, 8, 6);
        check("steady_period", period_cycles, 32'd16);
        check("steady_high",   high_cycles,   32'd8);
        check("steady_ns",     period_ns,     32'd128);

        // Duty and period change.
        run(3, 7, 5);
        check("duty_period", period_cycles, 32'd10);
        check("duty_high",   high_cycles,   32'd3);
        check("duty_ns",     period_ns,     32'd80);
        run(20, 20, 4);
        check("slow_period", period_cycles, 32'd40);
        check("slow_high",   high_cycles,   32'd20);
        check("slow_ns",     period_ns,     32'd320);

        // Stall: the input stops low, then restarts.
        run(5, 5, 3);
        level(1'b0, 120);
        check("stall_flag",   32'(stalled),  32'd1);
        check("stall_period", period_cycles, 32'd10);
        run(6, 6, 3);
        check("restart_flag",   32'(stalled),  32'd0);
        check("restart_period", period_cycles, 32'd12);

        // A period of exactly TimeoutCycles is published and does not stall.
        run(50, 50, 4);
        check("edge_period",  period_cycles, 32'd100);
        check("edge_stalled", 32'(stalled),  32'd0);

        // Enable dropped mid-period for 50 cycles.
        run(8, 8, 3);
        level(1'b1, 4);
        en_drv = 1'b0;
        level(1'b1, 4);
        level(1'b0, 8);
        run(8, 8, 2);
        level(1'b1, 6);
        check("disabled_hold", period_cycles, 32'd16);
        en_drv = 1'b1;
        level(1'b1, 2);
        level(1'b0, 8);
        run(8, 8, 3);
        check("reenable_period", period_cycles, 32'd16);

        // Reset mid-measurement with the input held high.
        run(8, 8, 2);
        level(1'b1, 3);
        rst_drv = 1'b1;
        level(1'b1, 1);
        check("midreset_period", period_cycles, 32'd0);
        check("midreset_ns",     period_ns,     32'd0);
        rst_drv = 1'b0;
        level(1'b1, 4);
        level(1'b0, 8);
        run(8, 8, 3);
        check("postreset_period", period_cycles, 32'd16);

        // Randomized waveforms, with an occasional long low that causes a stall.
        for (int i = 0; i < 20; i++) begin
            int h, l, n;
            h = int'($urandom_range(2, 40));
            l = ($urandom_range(0, 4) == 0) ? int'($urandom_range(90, 130))
                                            : int'($urandom_range(2, 40));
            n = int'($urandom_range(1, 4));
            run(h, l, n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the period and high time of a slow, asynchronous clock-like input (e.g. a divided clock, or a board signal) in MasterClock cycles. It is the consumer-side counterpart to the clock-division logic. It samples the input through a synchronizer, counts MasterClock cycles between consecutive rising edges, and publishes one measurement per input period with a single-cycle valid strobe. It sits in the clock-control area of the Zybo design and feeds status registers and debug logic.

## Interface
- MasterPeriod, 8, MasterClock period in ns; used only to scale the PeriodNs output.
- CountWidth, 32, width of all count outputs and of the internal counter.
- TimeoutCycles, 125_000_000, number of cycles without a rising edge before the stall is declared; must be < 2**CountWidth and ≥ 4.
- MasterClock  in  1  system clock (125 MHz on Zybo).
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  measurement enable; low forces the idle state.
- MeasuredClock  in  1  asynchronous input under measurement.
- PeriodCycles  out  CountWidth  last measured period in MasterClock cycles.
- HighCycles  out  CountWidth  last measured high time in MasterClock cycles.
- PeriodNs  out  CountWidth  PeriodCycles*MasterPeriod, truncated to CountWidth.
- MeasureValid  out  1  one-cycle strobe when the three outputs above update.
- Stalled  out  1  sticky flag: no rising edge seen within TimeoutCycles.

## Operation
- Synchronizer: two flops reset to 0, plus a third history flop for edge detection. Rise = sync & ~hist. Fall = ~sync & hist.
- Counter Cnt:
  - Loads 1 on the cycle after a detected rise.
  - Otherwise increments, saturating at TimeoutCycles.
  - Therefore a rise P cycles after the previous rise sees Cnt == P.
- HighLatch: loads Cnt on a detected fall.
- States:
  - WAIT_FIRST (reset state):
    - Cnt is held at 0 and no publishing occurs.
    - On a rise: load Cnt, move to MEASURING.
  - MEASURING, on a rise:
    - PeriodCycles <= Cnt; HighCycles <= HighLatch; PeriodNs <= Cnt*MasterPeriod.
    - MeasureValid <= 1 and Stalled <= 0.
    - Cnt reloads; remain in MEASURING.
  - MEASURING, Cnt == TimeoutCycles with no rise that cycle: Stalled <= 1, go to WAIT_FIRST. The outputs keep their last values.
- Simultaneous rise and Cnt == TimeoutCycles: the rise wins and a normal publish occurs (period = TimeoutCycles is valid).
- Enable low:
  - Go to WAIT_FIRST and clear Cnt and HighLatch.
  - MeasureValid stays 0; PeriodCycles, HighCycles, PeriodNs and Stalled hold.
  - The synchronizer keeps running, so an edge present at re-enable is detected normally.
- No fall between two rises (glitch-free input cannot produce this): HighCycles publishes the stale HighLatch value, which is not checked.
- Reset at any time:
  - All outputs 0, state WAIT_FIRST, Cnt = 0, HighLatch = 0, synchronizer flops = 0.
  - A MeasuredClock held high through reset produces one rise after release, which only starts counting.

## Timing
- Input-to-detection latency: 2–3 MasterClock cycles (synchronizer uncertainty). Measured values are exact for inputs generated synchronously to MasterClock and ±1 cycle for truly asynchronous inputs.
- MeasureValid rises on the cycle after the detected rise. The outputs change on that same cycle and remain stable until the next strobe.
- First MeasureValid follows the second detected rise after reset or re-enable.
- Minimum measurable period: 4 cycles. Minimum high or low time: 2 cycles.
- Stalled asserts on the cycle after Cnt reaches TimeoutCycles, i.e. TimeoutCycles+1 cycles after the last loaded rise.

## Test plan
- Steady input, high 8 / low 8 cycles, synchronous to MasterClock, after reset:
  - First MeasureValid after the second rise.
  - Then MeasureValid every 16 cycles with PeriodCycles=16, HighCycles=8, PeriodNs=128; Stalled=0.
- Duty/period change, high 3 / low 7, then switch to high 20 / low 20:
  - 10/3/80 reported until the switch.
  - Exactly one transitional value, then 40/20/320.
- TimeoutCycles=100, stop input low after a rise:
  - Stalled=1 at 101 cycles after the loaded rise; outputs hold their last values; no MeasureValid.
  - On restart, the second rise yields MeasureValid with Stalled=0.
- TimeoutCycles=100 and input period exactly 100: every period is published as 100; Stalled never asserts.
- Enable dropped mid-period for 50 cycles, then raised:
  - Outputs hold and there are no strobes while disabled.
  - First strobe after the second rise post-enable, with the correct period.
- Reset asserted mid-measurement with input running: all outputs read 0 on the following cycle; measurement resumes with the first strobe after the second rise post-reset.
